// File: rtl/poly_horner_pipe_if.sv
// Handshake/bus bundle for poly_horner_pipe: sample input, coefficient write port and result output.
// master = producer/consumer side, slave = the evaluator.
interface poly_horner_pipe_if #(
   parameter int unsigned XW  = 4,
   parameter int unsigned CW  = 4,
   parameter int unsigned DEG = 3,
   parameter int unsigned OW  = 12
);
   localparam int unsigned IW = $clog2(DEG + 1);

   logic          in_valid;
   logic          in_ready;
   logic [XW-1:0] in_x;
   logic          coef_we;
   logic [IW-1:0] coef_idx;
   logic [CW-1:0] coef_wdata;
   logic          coef_ready;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_data;
   logic          out_ovf;

   modport master (
      output in_valid, in_x, coef_we, coef_idx, coef_wdata, out_ready,
      input  in_ready, coef_ready, out_valid, out_data, out_ovf
   );

   modport slave (
      input  in_valid, in_x, coef_we, coef_idx, coef_wdata, out_ready,
      output in_ready, coef_ready, out_valid, out_data, out_ovf
   );
endinterface

// File: rtl/poly_horner_pipe.sv
// Pipelined unsigned polynomial evaluator (Horner's rule, one multiply-add per stage, global stall).
// Build option: define POLY_SAT_EN to clamp overflowing results to all-ones instead of wrapping.
module poly_horner_pipe #(
   parameter int unsigned XW  = 4,
   parameter int unsigned CW  = 4,
   parameter int unsigned DEG = 3,
   parameter int unsigned OW  = 12
) (
   input logic               clk,
   input logic               rst_n,
   poly_horner_pipe_if.slave bus
);
   localparam int unsigned IW = $clog2(DEG + 1);
   // Wide enough for acc*x + a without loss: < 2^(OW+XW) + 2^OW.
   localparam int unsigned FW = OW + XW + 1;

   logic [CW-1:0] coef_q [0:DEG];
   logic [DEG:0]  vld_q;
   logic [XW-1:0] x_q    [0:DEG-1];
   logic [OW-1:0] acc_q  [0:DEG];
   logic          ovf_q  [0:DEG];

   logic advance_c;
   logic coef_ready_c;
   logic coef_wr_c;
   logic accept_c;

   // Flow control: whole pipe shifts or whole pipe holds.
   assign advance_c    = !vld_q[DEG] || bus.out_ready;
   assign coef_ready_c = ~|vld_q;
   assign coef_wr_c    = bus.coef_we && coef_ready_c;
   assign accept_c     = bus.in_valid && advance_c && !coef_wr_c;

   assign bus.in_ready   = advance_c && !coef_wr_c;
   assign bus.coef_ready = coef_ready_c;
   assign bus.out_valid  = vld_q[DEG];
   assign bus.out_data   = acc_q[DEG];
   assign bus.out_ovf    = ovf_q[DEG];

   // Coefficient bank; indices above DEG match no entry and are dropped.
   for (genvar k = 0; k <= DEG; k++) begin : g_coef
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            coef_q[k] <= '0;
         end else if (coef_wr_c && (bus.coef_idx == IW'(k))) begin
            coef_q[k] <= bus.coef_wdata;
         end
      end
   end

   // Stage 0: capture x and seed the accumulator with the leading coefficient.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q[0] <= 1'b0;
         x_q[0]   <= '0;
         acc_q[0] <= '0;
         ovf_q[0] <= 1'b0;
      end else if (advance_c) begin
         vld_q[0] <= accept_c;
         x_q[0]   <= bus.in_x;
         acc_q[0] <= OW'(coef_q[DEG]);
         ovf_q[0] <= 1'b0;
      end
   end

   for (genvar k = 1; k <= DEG; k++) begin : g_stage
      logic [FW-1:0] full_c;
      logic [OW-1:0] acc_c;
      logic          ovf_c;

      // One Horner step at full precision, then wrap or clamp to OW bits.
      always_comb begin
         full_c = '0;
         acc_c  = '0;
         ovf_c  = 1'b0;
         full_c = (FW'(acc_q[k-1]) * FW'(x_q[k-1])) + FW'(coef_q[DEG-k]);
         ovf_c  = ovf_q[k-1] || (|full_c[FW-1:OW]);
`ifdef POLY_SAT_EN
         acc_c  = ovf_c ? {OW{1'b1}} : full_c[OW-1:0];
`else
         acc_c  = full_c[OW-1:0];
`endif
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q[k] <= 1'b0;
            acc_q[k] <= '0;
            ovf_q[k] <= 1'b0;
         end else if (advance_c) begin
            vld_q[k] <= vld_q[k-1];
            acc_q[k] <= acc_c;
            ovf_q[k] <= ovf_c;
         end
      end

      // x is only needed by stages that still have a multiply ahead.
      if (k < DEG) begin : g_x
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               x_q[k] <= '0;
            end else if (advance_c) begin
               x_q[k] <= x_q[k-1];
            end
         end
      end
   end
endmodule

// File: tb/tb_poly_horner_pipe.sv
// Scoreboard bench for poly_horner_pipe: driver pushes expected results from a polynomial model,
// an independent monitor pops and compares on every output handshake.
module tb_poly_horner_pipe;
   localparam int unsigned XW  = 4;
   localparam int unsigned CW  = 4;
   localparam int unsigned DEG = 3;
   localparam int unsigned OW  = 12;

   typedef struct {
      longint data;
      bit     ovf;
      int     acc_cyc;
      bit     lat_chk;
   } exp_t;

   logic clk;
   logic rst_n;

   poly_horner_pipe_if #(.XW(XW), .CW(CW), .DEG(DEG), .OW(OW)) bus ();

   poly_horner_pipe #(.XW(XW), .CW(CW), .DEG(DEG), .OW(OW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t q[$];
   int   a_m [0:DEG];
   int   n_vec, n_err, n_acc, n_take, cyc, stall_cnt;
   bit   lat_chk, rnd_ready, last_acc, last_cwr, last_in_rdy;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Value of the polynomial formed by the leading j+1 coefficients, evaluated at x.
   function automatic longint top_terms(input int x, input int j);
      longint s;
      longint t;
      s = 0;
      for (int i = 0; i <= j; i++) begin
         t = longint'(a_m[DEG-i]);
         for (int e = 0; e < j - i; e++) t = t * longint'(x);
         s = s + t;
      end
      return s;
   endfunction

   function automatic exp_t model(input int x);
      exp_t   e;
      longint y;
      bit     o;
      o = 1'b0;
      for (int j = 0; j <= DEG; j++)
         if (top_terms(x, j) >= (longint'(1) << OW)) o = 1'b1;
      y = top_terms(x, DEG);
      e.ovf = o;
`ifdef POLY_SAT_EN
      e.data = o ? ((longint'(1) << OW) - 1) : y;
`else
      e.data = y % (longint'(1) << OW);
`endif
      e.acc_cyc = 0;
      e.lat_chk = 1'b0;
      return e;
   endfunction

   // One clock: observe handshakes at the falling edge, then step to just after the rising edge.
   task automatic cycle();
      exp_t e;
      bit   exp_cr;
      @(negedge clk);
      last_acc    = 1'b0;
      last_cwr    = 1'b0;
      last_in_rdy = bus.in_ready;
      if (rst_n) begin
         exp_cr = (n_acc == n_take);
         check("coef_ready", longint'(bus.coef_ready), longint'(exp_cr));
         if (bus.coef_we && exp_cr) begin
            if (int'(bus.coef_idx) <= int'(DEG)) a_m[bus.coef_idx] = int'(bus.coef_wdata);
            last_cwr = 1'b1;
         end
         if (bus.in_valid && bus.in_ready) begin
            e = model(int'(bus.in_x));
            e.acc_cyc = cyc;
            e.lat_chk = lat_chk;
            q.push_back(e);
            n_acc++;
            last_acc = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      if (stall_cnt > 0) begin
         stall_cnt--;
         if (stall_cnt == 0) bus.out_ready = 1'b1;
      end else if (rnd_ready) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic send(input int x, output int n);
      bus.in_valid = 1'b1;
      bus.in_x     = XW'(x);
      n = 0;
      do begin
         cycle();
         n++;
      end while (!last_acc && n < 100);
      if (!last_acc) check("send_timeout", 0, 1);
   endtask

   task automatic wr_coef(input int idx, input int val);
      int n;
      bus.in_valid   = 1'b0;
      bus.coef_we    = 1'b1;
      bus.coef_idx   = 2'(idx);
      bus.coef_wdata = CW'(val);
      n = 0;
      do begin
         cycle();
         n++;
      end while (!last_cwr && n < 200);
      if (!last_cwr) check("coef_wr_timeout", 0, 1);
      bus.coef_we = 1'b0;
   endtask

   task automatic drain();
      int n;
      bus.in_valid = 1'b0;
      n = 0;
      while (n_acc != n_take && n < 200) begin
         cycle();
         n++;
      end
      if (n_acc != n_take) check("drain_timeout", longint'(n_acc - n_take), 0);
      cycle();
   endtask

   // Monitor: compares every taken result and the stall-hold behaviour.
   initial begin
      bit     take, pstall, povf;
      longint pdata;
      exp_t   e;
      pstall = 1'b0;
      povf   = 1'b0;
      pdata  = 0;
      forever begin
         @(negedge clk);
         take = 1'b0;
         if (rst_n) begin
            if (pstall) begin
               check("hold_valid", longint'(bus.out_valid), 1);
               check("hold_data", longint'(bus.out_data), pdata);
               check("hold_ovf", longint'(bus.out_ovf), longint'(povf));
            end
            if (bus.out_valid && !bus.out_ready)
               check("stall_in_ready", longint'(bus.in_ready), 0);
            if (bus.out_valid && bus.out_ready) begin
               take = 1'b1;
               if (q.size() == 0) begin
                  check("unexpected_out", 1, 0);
               end else begin
                  e = q.pop_front();
                  check("out_data", longint'(bus.out_data), e.data);
                  check("out_ovf", longint'(bus.out_ovf), longint'(e.ovf));
                  if (e.lat_chk) check("latency", longint'(cyc - e.acc_cyc), longint'(DEG + 1));
               end
            end
            pstall = bus.out_valid && !bus.out_ready;
            pdata  = longint'(bus.out_data);
            povf   = bus.out_ovf;
         end else begin
            pstall = 1'b0;
         end
         @(posedge clk);
         if (take && rst_n) n_take++;
      end
   end

   initial begin
      int n;
      int r;
      rst_n          = 1'b1;
      bus.in_valid   = 1'b0;
      bus.in_x       = '0;
      bus.coef_we    = 1'b0;
      bus.coef_idx   = '0;
      bus.coef_wdata = '0;
      bus.out_ready  = 1'b1;
      n_vec = 0; n_err = 0; n_acc = 0; n_take = 0; stall_cnt = 0;
      lat_chk = 1'b1; rnd_ready = 1'b0;
      for (int k = 0; k <= DEG; k++) a_m[k] = 0;

      #2 rst_n = 1'b0;
      #1;
      check("rst_out_valid", longint'(bus.out_valid), 0);
      check("rst_out_data", longint'(bus.out_data), 0);
      check("rst_out_ovf", longint'(bus.out_ovf), 0);
      check("rst_in_ready", longint'(bus.in_ready), 1);
      check("rst_coef_ready", longint'(bus.coef_ready), 1);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Cubic x^3 + 5
      wr_coef(3, 1); wr_coef(2, 0); wr_coef(1, 0); wr_coef(0, 5);
      send(3, n);
      bus.in_valid = 1'b0;
      send(15, n);
      drain();

      // Back-to-back stream, every sample accepted first try
      for (int x = 0; x < 8; x++) begin
         send(x, n);
         check("stream_accept_cycles", longint'(n), 1);
      end
      drain();

      // Overflow: 15x^3 + 5 at x = 15
      wr_coef(3, 15);
      send(15, n);
      drain();

      // Backpressure: 3-cycle stall mid-stream
      wr_coef(3, 1);
      lat_chk = 1'b0;
      for (int x = 1; x <= 6; x++) begin
         send(x, n);
         if (x == 4) begin
            bus.out_ready = 1'b0;
            stall_cnt     = 3;
         end
      end
      drain();
      lat_chk = 1'b1;

      // Write attempted with a sample in flight is ignored
      send(2, n);
      bus.in_valid   = 1'b0;
      bus.coef_we    = 1'b1;
      bus.coef_idx   = 2'd3;
      bus.coef_wdata = 4'd7;
      cycle();
      check("busy_write_ignored", longint'(last_cwr), 0);
      bus.coef_we = 1'b0;
      drain();

      // Write and sample together on an empty pipe: write wins, sample follows
      bus.coef_we    = 1'b1;
      bus.coef_idx   = 2'd1;
      bus.coef_wdata = 4'd4;
      bus.in_valid   = 1'b1;
      bus.in_x       = 4'd2;
      cycle();
      check("joint_write_taken", longint'(last_cwr), 1);
      check("joint_in_ready", longint'(last_in_rdy), 0);
      bus.coef_we = 1'b0;
      send(2, n);
      check("joint_sample_next", longint'(n), 1);
      drain();

      // Reset with three samples in flight
      send(3, n); send(4, n); send(5, n);
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", longint'(bus.out_valid), 0);
      check("midrst_out_data", longint'(bus.out_data), 0);
      check("midrst_out_ovf", longint'(bus.out_ovf), 0);
      check("midrst_coef_ready", longint'(bus.coef_ready), 1);
      q.delete();
      n_acc = 0; n_take = 0;
      for (int k = 0; k <= DEG; k++) a_m[k] = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      send(3, n);
      drain();

      // Randomised traffic with random backpressure and coefficient rewrites
      rnd_ready = 1'b1;
      lat_chk   = 1'b0;
      repeat (300) begin
         r = int'($urandom_range(0, 9));
         if (r == 0) begin
            wr_coef(int'($urandom_range(0, DEG)), int'($urandom_range(0, 15)));
         end else if (r <= 2) begin
            bus.in_valid = 1'b0;
            cycle();
         end else begin
            send(int'($urandom_range(0, 15)), n);
         end
      end
      rnd_ready     = 1'b0;
      bus.out_ready = 1'b1;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
